dmem_store_buffer: RTL and testbench

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

---
 rtl/dmem_store_buffer_pkg.sv | 20 ++
 rtl/dmem_store_buffer_sb_fifo_cam.sv | 104 ++++++++++
 rtl/dmem_store_buffer.sv | 159 +++++++++++++++
 tb/tb_dmem_store_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer_pkg
// Shared definitions for the data-memory store buffer:
//   - SB_DEPTH      : default number of store-buffer entries
//   - WORD_ADDR_W   : width of a word address (byte address bits [31:2])
//   - sb_state_e    : memory-side controller states
// ---------------------------------------------------------------------------
package dmem_store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int WORD_ADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        LDONE = 2'd3
    } sb_state_e;

endpackage

// File: rtl/dmem_store_buffer_sb_fifo_cam.sv
// ---------------------------------------------------------------------------
// sb_fifo_cam
// Circular store queue with an associative lookup port.
// Entries hold {word address, data}; the lookup returns the youngest valid
// entry whose word address matches.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   push, push_addr/data     enqueue at tail (ignored when full)
//   pop                      dequeue head (ignored when empty)
//   lookup_addr              word address to search for
//   hit, hit_data            youngest matching entry
//   head_addr, head_data     oldest entry, presented for draining
//   full, empty              occupancy flags
// ---------------------------------------------------------------------------
module sb_fifo_cam
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WORD_ADDR_W-1:0] push_addr,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    input  logic [WORD_ADDR_W-1:0] lookup_addr,
    output logic                   hit,
    output logic [31:0]            hit_data,
    output logic [WORD_ADDR_W-1:0] head_addr,
    output logic [31:0]            head_data,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]            data_mem [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic [PTR_W-1:0]       idx;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[tail_q] <= push_addr;
            data_mem[tail_q] <= push_data;
        end
    end

    // Walk oldest to youngest from head so a later match overrides an
    // earlier one, leaving the youngest store in hit_data.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_mem[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign head_addr = addr_mem[head_q];
    assign head_data = data_mem[head_q];

endmodule

// File: rtl/dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer
// Store buffer between the core and a single-ported external data memory.
// Stores retire into the buffer in one cycle and drain in the background;
// loads forward from the buffer on a hit, otherwise stall for a memory read.
//
// Ports:
//   clk, Reset                      clock, asynchronous active-low reset
//   memwrite, memread               core store / load request
//   addr, writedata                 byte address (bits [1:0] ignored), data
//   ReadData                        load data to writeback
//   stall                           core holds PC and inputs while high
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       external memory request
//   mem_ack, mem_rdata              external memory completion / read data
// ---------------------------------------------------------------------------
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    sb_state_e              state_q;
    sb_state_e              state_d;
    logic [WORD_ADDR_W-1:0] word_addr;
    logic                   load_req;
    logic                   load_hit;
    logic                   load_miss;
    logic                   push;
    logic                   pop;
    logic                   capture;
    logic                   full;
    logic                   empty;
    logic [31:0]            hit_data;
    logic [WORD_ADDR_W-1:0] head_addr;
    logic [31:0]            head_data;
    logic [31:0]            load_data_q;
    logic                   byte_offset_unused;

    // The byte offset is deliberately ignored; all matching is per word.
    assign word_addr          = addr[31:2];
    assign byte_offset_unused = ^addr[1:0];

    // A store takes precedence over a simultaneous load request.
    assign load_req  = memread && !memwrite;
    assign load_miss = load_req && !load_hit;

    // Fullness is judged before any same-cycle pop, so a drain completing
    // in the same cycle does not let a stalled store in early.
    assign push = memwrite && !full;

    sb_fifo_cam #(
        .DEPTH(DEPTH)
    ) u_fifo_cam (
        .clk        (clk),
        .rst_n      (Reset),
        .push       (push),
        .push_addr  (word_addr),
        .push_data  (writedata),
        .pop        (pop),
        .lookup_addr(word_addr),
        .hit        (load_hit),
        .hit_data   (hit_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE arbitrates: a pending load miss beats draining, so a load that
    // arrived during a drain is served right after that drain finishes.
    // The memory request group is decoded from state, so reset drops it at once.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d = LOAD;
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {head_addr, 2'b00};
                mem_wdata = head_data;
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                mem_req  = 1'b1;
                mem_addr = {word_addr, 2'b00};
                if (mem_ack) begin
                    capture = 1'b1;
                    state_d = LDONE;
                end
            end
            LDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            load_data_q <= '0;
        end else if (capture) begin
            load_data_q <= mem_rdata;
        end
    end

    // LDONE is the single cycle where a missed load is released.
    assign stall = (memwrite && full) || (load_miss && (state_q != LDONE));

    always_comb begin
        ReadData = '0;
        if (state_q == LDONE) begin
            ReadData = load_data_q;
        end else if (load_req && load_hit) begin
            ReadData = hit_data;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_dmem_store_buffer
// Directed, table-driven bench for dmem_store_buffer (DEPTH = 4).
// Each vector is one clock cycle: inputs are driven after the falling edge
// and outputs are compared 1 ns later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_store_buffer;

    typedef struct {
        bit          memwrite;
        bit          memread;
        logic [31:0] addr;
        logic [31:0] writedata;
        bit          mem_ack;
        logic [31:0] mem_rdata;
        bit          e_stall;
        logic [31:0] e_read_data;
        bit          e_mem_req;
        bit          e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
    } vec_t;

    logic        clk;
    logic        Reset;
    logic        memwrite;
    logic        memread;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] ReadData;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int   tests_run;
    int   tests_failed;
    vec_t vecs[$];

    localparam logic [31:0] DB = 32'hDEADBEEF;

    dmem_store_buffer #(
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .memwrite (memwrite),
        .memread  (memread),
        .addr     (addr),
        .writedata(writedata),
        .ReadData (ReadData),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit w, bit r, logic [31:0] a, logic [31:0] wd,
                                bit ack, logic [31:0] rd, bit es,
                                logic [31:0] erd, bit ereq, bit ewe,
                                logic [31:0] emaddr, logic [31:0] emwd);
        vec_t v;
        v.memwrite    = w;
        v.memread     = r;
        v.addr        = a;
        v.writedata   = wd;
        v.mem_ack     = ack;
        v.mem_rdata   = rd;
        v.e_stall     = es;
        v.e_read_data = erd;
        v.e_mem_req   = ereq;
        v.e_mem_we    = ewe;
        v.e_mem_addr  = emaddr;
        v.e_mem_wdata = emwd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        memwrite  = v.memwrite;
        memread   = v.memread;
        addr      = v.addr;
        writedata = v.writedata;
        mem_ack   = v.mem_ack;
        mem_rdata = v.mem_rdata;
        #1;
    endtask

    task automatic check_vector(input int i, input vec_t v);
        check_output($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, v.e_stall});
        check_output($sformatf("v%0d ReadData", i), ReadData, v.e_read_data);
        check_output($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, v.e_mem_req});
        check_output($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, v.e_mem_we});
        check_output($sformatf("v%0d mem_addr", i), mem_addr, v.e_mem_addr);
        check_output($sformatf("v%0d mem_wdata", i), mem_wdata, v.e_mem_wdata);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b0;
        memwrite     = 1'b0;
        memread      = 1'b0;
        addr         = '0;
        writedata    = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;

        // Single store drained with a three-cycle acknowledge.
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h100,DB,0,0,          0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,1,1,'h100,DB));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,1,1,'h100,DB));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h100,DB));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        // Two stores to one word: youngest forwards, older entry drains first.
        vecs.push_back(mk(1,0,'h20,1,0,0,            0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h20,2,0,0,            0,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h22,0,0,0,            0,2,1,1,'h20,1));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h20,1));
        vecs.push_back(mk(0,1,'h20,0,0,0,            0,2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h20,2));
        // Same word now only in memory: a full load miss round trip.
        vecs.push_back(mk(0,1,'h21,0,0,0,            1,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h21,0,0,0,            1,0,1,0,'h20,0));
        vecs.push_back(mk(0,1,'h21,0,1,2,            1,0,1,0,'h20,0));
        vecs.push_back(mk(0,1,'h21,0,0,0,            0,2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        // Load miss arriving during an in-flight drain.
        vecs.push_back(mk(1,0,'h10,'hAA,0,0,         0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h40,0,0,0,            1,0,1,1,'h10,'hAA));
        vecs.push_back(mk(0,1,'h40,0,1,0,            1,0,1,1,'h10,'hAA));
        vecs.push_back(mk(0,1,'h40,0,0,0,            1,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h40,0,1,'h55,         1,0,1,0,'h40,0));
        vecs.push_back(mk(0,1,'h40,0,0,0,            0,'h55,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        // Five back-to-back stores into a four-entry buffer, then full drain.
        vecs.push_back(mk(1,0,'h200,1,0,0,           0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h204,2,0,0,           0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h208,3,0,0,           0,0,1,1,'h200,1));
        vecs.push_back(mk(1,0,'h20C,4,0,0,           0,0,1,1,'h200,1));
        vecs.push_back(mk(1,0,'h210,5,0,0,           1,0,1,1,'h200,1));
        vecs.push_back(mk(1,0,'h210,5,1,0,           1,0,1,1,'h200,1));
        vecs.push_back(mk(1,0,'h210,5,0,0,           0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h204,2));
        vecs.push_back(mk(1,1,'h300,'h77,0,0,        0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h208,3));
        vecs.push_back(mk(0,1,'h210,0,0,0,           0,5,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h20C,4));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h210,5));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,               0,0,1,1,'h300,'h77));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,               0,0,0,0,0,0));
        // Build up to a LOAD with two entries still buffered.
        vecs.push_back(mk(1,0,'h400,'hA1,0,0,        0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h404,'hA2,0,0,        0,0,0,0,0,0));
        vecs.push_back(mk(1,0,'h408,'hA3,0,0,        0,0,1,1,'h400,'hA1));
        vecs.push_back(mk(0,1,'h500,0,1,0,           1,0,1,1,'h400,'hA1));
        vecs.push_back(mk(0,1,'h500,0,0,0,           1,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h500,0,0,0,           1,0,1,0,'h500,0));

        // Outputs while reset is held.
        #3;
        check_output("reset mem_req", {31'b0, mem_req}, 32'd0);
        check_output("reset mem_we", {31'b0, mem_we}, 32'd0);
        check_output("reset mem_addr", mem_addr, 32'd0);
        check_output("reset mem_wdata", mem_wdata, 32'd0);
        check_output("reset ReadData", ReadData, 32'd0);
        check_output("reset stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_vector(i, vecs[i]);
        end

        // Reset asserted mid-LOAD: the request must drop without a clock edge.
        #1;
        Reset = 1'b0;
        #1;
        check_output("midload mem_req", {31'b0, mem_req}, 32'd0);
        check_output("midload mem_we", {31'b0, mem_we}, 32'd0);
        check_output("midload mem_addr", mem_addr, 32'd0);
        check_output("midload ReadData", ReadData, 32'd0);
        @(negedge clk);
        memread = 1'b0;
        addr    = '0;
        Reset   = 1'b1;

        // Buffered stores were discarded, so no drain may ever start.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("post-reset c%0d mem_req", c), {31'b0, mem_req}, 32'd0);
            check_output($sformatf("post-reset c%0d stall", c), {31'b0, stall}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
